// File: rtl/day1_pkg.sv
// rtl/day1_pkg.sv - shared types and constants for the Day 1 command sequencer and dial
package day1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIGITS = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } seq_state_t;

  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam int DIAL_SIZE = 100;
  localparam int START_POS = 50;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/day1_dec_accum.sv
// rtl/day1_dec_accum.sv - decimal digit accumulator with overflow and digit-limit detection
module day1_dec_accum
  import day1_pkg::*;
#(
  parameter int AMT_W      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int ND_W       = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [3:0]       i_digit,
  output logic [AMT_W-1:0] o_acc,
  output logic [AMT_W-1:0] o_acc_next,
  output logic [ND_W-1:0]  o_ndigits,
  output logic             o_ovf
);

  // Four guard bits so acc*10+9 of any in-range value is representable and the
  // overflow compare sees the true result instead of a wrapped one.
  localparam logic [AMT_W+3:0] MAX_AMT = {4'b0000, {AMT_W{1'b1}}};

  logic [AMT_W+3:0] r_acc;
  logic [ND_W-1:0]  r_ndigits;
  logic [AMT_W+3:0] w_next;

  // Candidate value if the presented digit were absorbed this cycle.
  always_comb begin
    w_next = (r_acc << 3) + (r_acc << 1) + {{AMT_W{1'b0}}, i_digit};
  end

  // ovf is a look-ahead: the FSM uses it to reject the digit before absorbing it.
  assign o_ovf      = (r_ndigits == ND_W'(MAX_DIGITS)) || (w_next > MAX_AMT);
  assign o_acc      = r_acc[AMT_W-1:0];
  assign o_acc_next = w_next[AMT_W-1:0];
  assign o_ndigits  = r_ndigits;

  // Accumulator and digit counter; clear wins over enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc     <= '0;
      r_ndigits <= '0;
    end else if (i_clr) begin
      r_acc     <= '0;
      r_ndigits <= '0;
    end else if (i_en) begin
      r_acc     <= w_next;
      r_ndigits <= r_ndigits + 1'b1;
    end
  end

endmodule

// File: rtl/day1_cmd_sequencer.sv
// rtl/day1_cmd_sequencer.sv - ASCII rotation-line parser issuing one dial command per line
module day1_cmd_sequencer
  import day1_pkg::*;
#(
  parameter int AMT_W      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_last,
  output logic             o_cmd_valid,
  output logic             o_cmd_dir,
  output logic [AMT_W-1:0] o_cmd_amt,
  output logic [31:0]      o_cmd_count,
  output logic             o_done,
  output logic             o_err
);

  localparam int ND_W = $clog2(MAX_DIGITS + 1);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic             r_in_ready;
  logic             r_line_dir;
  logic             r_last_pend;
  logic             r_cmd_dir;
  logic [AMT_W-1:0] r_cmd_amt;
  logic [31:0]      r_cmd_count;
  logic             r_done;
  logic             r_err;

  logic             w_xfer;
  logic             w_is_digit;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic             w_dir_set;
  logic             w_last_set;
  logic             w_amt_from_next;
  logic [AMT_W-1:0] w_acc;
  logic [AMT_W-1:0] w_acc_next;
  logic [ND_W-1:0]  w_ndigits;
  logic             w_ovf;

  assign w_xfer     = i_in_valid && r_in_ready;
  assign w_is_digit = is_digit(i_in_data);

  // For '0'..'9' the low nibble of the ASCII code is the digit value.
  day1_dec_accum #(
    .AMT_W      (AMT_W),
    .MAX_DIGITS (MAX_DIGITS),
    .ND_W       (ND_W)
  ) u_accum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_acc_clr),
    .i_en       (w_acc_en),
    .i_digit    (i_in_data[3:0]),
    .o_acc      (w_acc),
    .o_acc_next (w_acc_next),
    .o_ndigits  (w_ndigits),
    .o_ovf      (w_ovf)
  );

  // Next-state and control decode; clr overrides every transition.
  always_comb begin
    w_next_state    = r_state;
    w_acc_clr       = 1'b0;
    w_acc_en        = 1'b0;
    w_dir_set       = 1'b0;
    w_last_set      = 1'b0;
    w_amt_from_next = 1'b0;
    if (i_clr) begin
      w_next_state = ST_IDLE;
      w_acc_clr    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (i_in_data == ASCII_L || i_in_data == ASCII_R) begin
              if (i_in_last) begin
                w_next_state = ST_ERROR;
              end else begin
                w_next_state = ST_DIGITS;
                w_acc_clr    = 1'b1;
                w_dir_set    = 1'b1;
              end
            end else if (i_in_data == ASCII_LF || i_in_data == ASCII_CR) begin
              if (i_in_last) w_next_state = ST_DONE;
            end else begin
              w_next_state = ST_ERROR;
            end
          end
        end
        ST_DIGITS: begin
          if (w_xfer) begin
            if (w_is_digit) begin
              if (w_ovf) begin
                w_next_state = ST_ERROR;
              end else begin
                w_acc_en = 1'b1;
                if (i_in_last) begin
                  w_next_state    = ST_ISSUE;
                  w_last_set      = 1'b1;
                  w_amt_from_next = 1'b1;
                end
              end
            end else if (i_in_data == ASCII_CR) begin
              // A final CR closes the line like a newline would.
              if (i_in_last) begin
                if (w_ndigits != '0) begin
                  w_next_state = ST_ISSUE;
                  w_last_set   = 1'b1;
                end else begin
                  w_next_state = ST_ERROR;
                end
              end
            end else if (i_in_data == ASCII_LF) begin
              if (w_ndigits != '0) begin
                w_next_state = ST_ISSUE;
                w_last_set   = i_in_last;
              end else begin
                w_next_state = ST_ERROR;
              end
            end else begin
              w_next_state = ST_ERROR;
            end
          end
        end
        ST_ISSUE: w_next_state = r_last_pend ? ST_DONE : ST_IDLE;
        ST_DONE:  w_next_state = ST_DONE;
        ST_ERROR: w_next_state = ST_ERROR;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Registered handshake, command payload and sticky status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_ready  <= 1'b0;
      r_line_dir  <= 1'b0;
      r_last_pend <= 1'b0;
      r_cmd_dir   <= 1'b0;
      r_cmd_amt   <= '0;
      r_cmd_count <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_in_ready <= (w_next_state == ST_IDLE) || (w_next_state == ST_DIGITS);
      if (w_dir_set) r_line_dir <= (i_in_data == ASCII_R);
      if (i_clr) begin
        r_last_pend <= 1'b0;
        r_cmd_count <= '0;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        // Payload and count are loaded on entry to ISSUE so they are visible
        // in the same cycle as the strobe.
        if (w_next_state == ST_ISSUE && r_state != ST_ISSUE) begin
          r_cmd_dir   <= r_line_dir;
          r_cmd_amt   <= w_amt_from_next ? w_acc_next : w_acc;
          r_cmd_count <= r_cmd_count + 32'd1;
          r_last_pend <= w_last_set;
        end
        if (w_next_state == ST_DONE)  r_done <= 1'b1;
        if (w_next_state == ST_ERROR) r_err  <= 1'b1;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_cmd_valid = (r_state == ST_ISSUE) && !i_clr;
  assign o_cmd_dir   = r_cmd_dir;
  assign o_cmd_amt   = r_cmd_amt;
  assign o_cmd_count = r_cmd_count;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: doc/day1_cmd_sequencer.md
# day1_cmd_sequencer

Front-end controller for the Day 1 dial datapath. Accepts the raw puzzle input as an ASCII byte stream (valid/ready), parses each rotation line ('L'/'R' followed by decimal digits and a newline), and issues exactly one single-cycle `valid`/`dir`/`amt` command per line to the dial core. It also tracks command count, end-of-input and parse errors, so the dial never sees a malformed or partial command.

## Interface
- `AMT_W`, 16: width of the issued amount; matches the dial `amt` port.
- `MAX_DIGITS`, 5: maximum decimal digits per line; a further digit is an error.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear; returns the block to IDLE and zeroes `cmd_count`, `done` and `err`.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  block accepts a byte; a byte transfers when `in_valid && in_ready`.
- `in_data`  in  8  ASCII byte.
- `in_last`  in  1  marks the final byte of the input; qualified by the transfer.
- `cmd_valid`  out  1  one-cycle command strobe; drives the dial `valid`.
- `cmd_dir`  out  1  1 = 'R' (add), 0 = 'L' (subtract).
- `cmd_amt`  out  AMT_W  parsed decimal amount.
- `cmd_count`  out  32  number of commands issued since reset or `clr`.
- `done`  out  1  sticky; end of input reached and the last command has been issued.
- `err`  out  1  sticky; parse error detected.

## Operation
- States: IDLE (expect direction), DIGITS (accumulate), ISSUE (strobe), DONE, ERROR.
- IDLE behaviour:
  - 'L' (0x4C) or 'R' (0x52): latch the direction, clear the accumulator and digit count, go to DIGITS.
  - 0x0A or 0x0D: ignored, so blank lines and CRLF are allowed.
  - Any other byte: go to ERROR.
- DIGITS behaviour:
  - '0'–'9': `acc = acc*10 + (byte-0x30)`, digit count +1.
  - 0x0D: ignored.
  - 0x0A with digit count ≥ 1: go to ISSUE.
  - 0x0A with zero digits: go to ERROR.
  - Any other byte: go to ERROR.
- Arithmetic: the accumulator is AMT_W+4 bits wide. A result above 2^AMT_W−1, or a digit beyond MAX_DIGITS, goes to ERROR. Never saturate or truncate, because the dial reduces `amt` modulo its size.
- ISSUE: `cmd_valid` = 1 for this cycle only, and `cmd_count` increments. Next state is DONE if the end of input is pending, otherwise IDLE.
- `in_last` handling:
  - In IDLE on a newline or CR: go to DONE.
  - In DIGITS on a newline, or on a digit with ≥1 digit accumulated after that digit is absorbed: go to ISSUE, then DONE. A missing trailing newline is legal.
  - In DIGITS on a byte that would otherwise error, or in IDLE on 'L'/'R': go to ERROR.
- DONE and ERROR hold until `clr` or reset. `done` and `err` are never both 1.
- `clr` has priority over every transition in the same cycle. A command in ISSUE when `clr` is asserted is dropped: `cmd_valid` = 0.

## Timing
- Reset values while `rst_n` = 0:
  - state = IDLE
  - `in_ready` = 0, `cmd_valid` = 0, `cmd_dir` = 0
  - `cmd_amt` = 0, `cmd_count` = 0, `done` = 0, `err` = 0
- `in_ready` is registered. It is 1 in IDLE and DIGITS, and 0 in ISSUE, DONE and ERROR.
- Latency: terminator accepted at cycle N → `cmd_valid` high at N+1 → `in_ready` high again at N+2.
- Throughput: "R48\n" takes 4 transfers plus 1 bubble, i.e. 5 cycles per command.
- `cmd_dir` and `cmd_amt` are registered. They are valid while `cmd_valid` = 1 and hold their value until the next ISSUE.
- `cmd_count` increments in the same cycle as `cmd_valid`. `done` rises the cycle after the final ISSUE.
- Asynchronous reset mid-line discards the partial command. No `cmd_valid` is emitted.

## Structure
- Package `day1_pkg` holds:
  - The state enum `seq_state_t`.
  - ASCII constants `ASCII_L`, `ASCII_R`, `ASCII_LF`, `ASCII_CR`, `ASCII_0`, `ASCII_9`.
  - `DIAL_SIZE` and `START_POS`, shared with the dial.
- One sub-module, `day1_dec_accum`. It takes clear/enable/digit inputs and drives `acc`, `ndigits` and `ovf` outputs for the multiply-by-10 and add with overflow detection. The FSM stays in the top module.

## Test plan
- "L68\nR48\n" streamed without gaps → two strobes, (0,68) then (1,48), 5 cycles apart; `cmd_count` = 2.
- "R5\r\n\n\nL0" with `in_last` on '0' → strobes (1,5) then (0,0); `done` = 1 one cycle after the second strobe; `err` = 0.
- "R65536\n" with AMT_W = 16 → ERROR on the sixth byte '6' (overflow); no strobe; `in_ready` = 0; `err` = 1. Then `clr` followed by "L1\n" → strobe (0,1) and `cmd_count` = 1.
- "X12\n", "L\n" and "L1a\n" → each gives ERROR and no strobe.
- Randomized `in_valid` gaps on a 200-line file with the dial attached → zero-crossing count matches the software model; exactly one strobe per line.
- `rst_n` asserted after "R4" (before '\n') → all outputs return to reset values immediately; the following "L10\n" → single strobe (0,10).
